// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, sequencer states and the default
// device timing used by both the init/refresh engine and the read/write controller.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_MRS       = 4'b0000;

    typedef enum logic [3:0] {
        S_PWRUP,
        S_PRE,
        S_TRP,
        S_IREF,
        S_IRFC,
        S_MRS,
        S_TMRD,
        S_IDLE,
        S_AREF,
        S_RFC
    } sdram_state_t;

    localparam int          DEF_CLK_MHZ        = 100;
    localparam int          DEF_T_POWERUP_US   = 200;
    localparam int          DEF_T_RP           = 2;
    localparam int          DEF_T_RFC          = 7;
    localparam int          DEF_T_MRD          = 2;
    localparam int          DEF_INIT_REFRESH   = 8;
    localparam int          DEF_REFRESH_PERIOD = 781;
    localparam logic [12:0] DEF_MODE_REG       = 13'h032;

    // A command of spacing t is followed by t-1 wait cycles; the wait counter
    // starts at 0, so the final wait cycle shows a count of t-2.
    function automatic logic [15:0] wait_last(input int t_cycles);
        return 16'(t_cycles - 2);
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval timer: raises ref_req on every wrap and flags
// a sticky overrun when a wrap finds the previous request still pending.
module sdram_refresh_timer #(
    parameter int REFRESH_PERIOD = 781
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic ref_req,
    output logic ref_overrun
);

    localparam int            CNT_W    = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = enable && (cnt == CNT_LAST);

    // The counter never pauses for grants, so refresh cadence stays locked to
    // the period no matter how long the arbiter takes to respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            ref_req     <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            if (enable) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
            end
            if (wrap) begin
                ref_req <= 1'b1;
            end else if (clear) begin
                ref_req <= 1'b0;
            end
            if (wrap && ref_req && !clear) begin
                ref_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up initialization sequencer and auto-refresh engine.
// Define SDRAM_SIM_FAST_INIT_EN to shorten the power-up wait to 16 cycles for simulation.
module sdram_init_refresh
    import sdram_pkg::*;
#(
    parameter int          CLK_MHZ        = DEF_CLK_MHZ,
    parameter int          T_POWERUP_US   = DEF_T_POWERUP_US,
    parameter int          T_RP           = DEF_T_RP,
    parameter int          T_RFC          = DEF_T_RFC,
    parameter int          T_MRD          = DEF_T_MRD,
    parameter int          INIT_REFRESH   = DEF_INIT_REFRESH,
    parameter int          REFRESH_PERIOD = DEF_REFRESH_PERIOD,
    parameter logic [12:0] MODE_REG       = DEF_MODE_REG
) (
    input  logic        clk,
    input  logic        rst,
    output logic        sdr_cke,
    output logic [3:0]  sdr_cmd,
    output logic [12:0] sdr_addr,
    output logic [1:0]  sdr_ba,
    output logic        init_done,
    output logic        ref_req,
    input  logic        ref_grant,
    output logic        ref_busy,
    output logic        ref_overrun
);

`ifdef SDRAM_SIM_FAST_INIT_EN
    localparam int PWRUP_CYCLES = 16;
`else
    localparam int PWRUP_CYCLES = CLK_MHZ * T_POWERUP_US;
`endif

    localparam logic [15:0] PWRUP_LAST = 16'(PWRUP_CYCLES - 1);
    localparam logic [15:0] TRP_LAST   = wait_last(T_RP);
    localparam logic [15:0] RFC_LAST   = wait_last(T_RFC);
    localparam logic [15:0] MRD_LAST   = wait_last(T_MRD);
    localparam logic [7:0]  INIT_REF_N = 8'(INIT_REFRESH);

    sdram_state_t state;
    sdram_state_t state_next;
    logic [15:0]  wait_cnt;
    logic [15:0]  wait_cnt_next;
    logic [7:0]   iref_cnt;
    logic [7:0]   iref_cnt_next;

    logic [3:0]   cmd_next;
    logic [12:0]  addr_next;
    logic [1:0]   ba_next;
    logic         busy_next;
    logic         done_next;
    logic         aref_now;

    // Next-state logic. Wait states with a zero-length wait are skipped.
    // In S_PWRUP, a low sdr_cke marks the reset cycle, which is not counted.
    always_comb begin
        state_next = state;
        case (state)
            S_PWRUP: if (sdr_cke && wait_cnt == PWRUP_LAST) state_next = S_PRE;
            S_PRE:   state_next = (T_RP > 1) ? S_TRP : S_IREF;
            S_TRP:   if (wait_cnt == TRP_LAST) state_next = S_IREF;
            S_IREF: begin
                if (T_RFC > 1) begin
                    state_next = S_IRFC;
                end else if (iref_cnt + 8'd1 >= INIT_REF_N) begin
                    state_next = S_MRS;
                end else begin
                    state_next = S_IREF;
                end
            end
            S_IRFC: begin
                if (wait_cnt == RFC_LAST) begin
                    state_next = (iref_cnt >= INIT_REF_N) ? S_MRS : S_IREF;
                end
            end
            S_MRS:   state_next = (T_MRD > 1) ? S_TMRD : S_IDLE;
            S_TMRD:  if (wait_cnt == MRD_LAST) state_next = S_IDLE;
            S_IDLE:  if (ref_req && ref_grant) state_next = S_AREF;
            S_AREF:  state_next = (T_RFC > 1) ? S_RFC : S_IDLE;
            S_RFC:   if (wait_cnt == RFC_LAST) state_next = S_IDLE;
            default: state_next = S_PWRUP;
        endcase
    end

    // One shared wait counter, restarted from zero whenever a state is entered.
    always_comb begin
        wait_cnt_next = wait_cnt + 16'd1;
        if (!sdr_cke || state_next != state || state_next == S_IDLE) begin
            wait_cnt_next = '0;
        end
        iref_cnt_next = (state == S_IREF) ? iref_cnt + 8'd1 : iref_cnt;
    end

    // Outputs are decoded from the next state so the registered bus lines up
    // with the state register in the same cycle.
    always_comb begin
        cmd_next  = CMD_NOP;
        addr_next = '0;
        ba_next   = '0;
        case (state_next)
            S_PRE: begin
                cmd_next      = CMD_PRECHARGE;
                addr_next[10] = 1'b1;
            end
            S_IREF, S_AREF: cmd_next = CMD_AREF;
            S_MRS: begin
                cmd_next  = CMD_MRS;
                addr_next = MODE_REG;
            end
            default: cmd_next = CMD_NOP;
        endcase
        busy_next = (state_next != S_IDLE);
        done_next = init_done || (state_next == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_PWRUP;
            wait_cnt  <= '0;
            iref_cnt  <= '0;
            sdr_cke   <= 1'b0;
            sdr_cmd   <= CMD_NOP;
            sdr_addr  <= '0;
            sdr_ba    <= '0;
            init_done <= 1'b0;
            ref_busy  <= 1'b1;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            iref_cnt  <= iref_cnt_next;
            sdr_cke   <= 1'b1;
            sdr_cmd   <= cmd_next;
            sdr_addr  <= addr_next;
            sdr_ba    <= ba_next;
            init_done <= done_next;
            ref_busy  <= busy_next;
        end
    end

    assign aref_now = (state == S_AREF);

    sdram_refresh_timer #(
        .REFRESH_PERIOD (REFRESH_PERIOD)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .enable      (init_done),
        .clear       (aref_now),
        .ref_req     (ref_req),
        .ref_overrun (ref_overrun)
    );

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Scoreboard bench for sdram_init_refresh: init command sequence, refresh
// timing, overrun, ignored grants and mid-init reset.
module tb_sdram_init_refresh;
    import sdram_pkg::*;

`ifdef SDRAM_SIM_FAST_INIT_EN
    localparam int TB_CLK_MHZ  = 100;
    localparam int TB_PWRUP_US = 200;
    localparam int P           = 16;
`else
    localparam int TB_CLK_MHZ  = 1;
    localparam int TB_PWRUP_US = 50;
    localparam int P           = 50;
`endif
    // PRECHARGE + tRP, eight AREF + tRFC, MRS + tMRD.
    localparam int D = P + 2 + 8 * 7 + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        sdr_cke;
    logic [3:0]  sdr_cmd;
    logic [12:0] sdr_addr;
    logic [1:0]  sdr_ba;
    logic        init_done;
    logic        ref_req;
    logic        ref_grant;
    logic        ref_busy;
    logic        ref_overrun;

    int cyc = -1;
    int total = 0;
    int bad = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  ba;
    } exp_t;
    exp_t expq[$];

    sdram_init_refresh #(
        .CLK_MHZ      (TB_CLK_MHZ),
        .T_POWERUP_US (TB_PWRUP_US)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sdr_cke     (sdr_cke),
        .sdr_cmd     (sdr_cmd),
        .sdr_addr    (sdr_addr),
        .sdr_ba      (sdr_ba),
        .init_done   (init_done),
        .ref_req     (ref_req),
        .ref_grant   (ref_grant),
        .ref_busy    (ref_busy),
        .ref_overrun (ref_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

    // Monitor: every non-NOP command must match the head of the expected queue.
    always @(negedge clk) begin
        if (sdr_cmd != CMD_NOP) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("[TB] FAIL sb_unexpected cyc=%0d: got cmd=%h addr=%h ba=%h, expected none",
                         cyc, sdr_cmd, sdr_addr, sdr_ba);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (e.cyc != cyc || e.cmd != sdr_cmd || e.addr != sdr_addr || e.ba != sdr_ba) begin
                    bad++;
                    $display("[TB] FAIL sb_cmd: got cyc=%0d cmd=%h addr=%h ba=%h, expected cyc=%0d cmd=%h addr=%h ba=%h",
                             cyc, sdr_cmd, sdr_addr, sdr_ba, e.cyc, e.cmd, e.addr, e.ba);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic waitUntil(input int target);
        int guard = 0;
        while (cyc < target) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                total++;
                bad++;
                $display("[TB] FAIL timeout waiting for cycle %0d, at %0d", target, cyc);
                break;
            end
        end
    endtask

    task automatic applyStimulus(input int at_cycle, input logic grant);
        waitUntil(at_cycle);
        ref_grant = grant;
    endtask

    task automatic pushExpected(input int c, input logic [3:0] cmd, input logic [12:0] addr);
        exp_t e;
        e.cyc  = c;
        e.cmd  = cmd;
        e.addr = addr;
        e.ba   = 2'b00;
        expq.push_back(e);
    endtask

    task automatic pushInit(input int limit);
        if (P < limit) pushExpected(P, CMD_PRECHARGE, 13'h400);
        for (int k = 0; k < 8; k++) begin
            if (P + 2 + 7 * k < limit) pushExpected(P + 2 + 7 * k, CMD_AREF, 13'h000);
        end
        if (P + 58 < limit) pushExpected(P + 58, CMD_MRS, 13'h032);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cke"},  sdr_cke, 0);
        checkOutput({tag, "_cmd"},  sdr_cmd, CMD_NOP);
        checkOutput({tag, "_addr"}, sdr_addr, 0);
        checkOutput({tag, "_ba"},   sdr_ba, 0);
        checkOutput({tag, "_done"}, init_done, 0);
        checkOutput({tag, "_req"},  ref_req, 0);
        checkOutput({tag, "_busy"}, ref_busy, 1);
        checkOutput({tag, "_ovr"},  ref_overrun, 0);
    endtask

    initial begin
        rst = 1'b1;
        ref_grant = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("rst0");

        // First run, interrupted by reset at cycle 40.
        pushInit(40);
        rst = 1'b0;
        waitUntil(0);
        checkOutput("cke_c0", sdr_cke, 1);
        applyStimulus(5, 1'b1);
        applyStimulus(6, 1'b0);
        applyStimulus(20, 1'b1);
        applyStimulus(21, 1'b0);
        waitUntil(40);
        rst = 1'b1;
        @(negedge clk);
        checkResetValues("rst_mid");
        checkOutput("q_mid", expq.size(), 0);

        // Full init, with grants pulsed that must be ignored.
        pushInit(32'h7fffffff);
        rst = 1'b0;
        applyStimulus(10, 1'b1);
        applyStimulus(11, 1'b0);
        applyStimulus(P + 5, 1'b1);
        applyStimulus(P + 6, 1'b0);
        waitUntil(P);
        checkOutput("busy_pre", ref_busy, 1);
        applyStimulus(P + 30, 1'b1);
        applyStimulus(P + 31, 1'b0);
        waitUntil(D - 1);
        checkOutput("done_before", init_done, 0);
        checkOutput("busy_before", ref_busy, 1);
        waitUntil(D);
        checkOutput("done_at", init_done, 1);
        checkOutput("busy_at", ref_busy, 0);
        checkOutput("req_at", ref_req, 0);

        // Refresh with grant held high before the request appears.
        pushExpected(D + 782, CMD_AREF, 13'h000);
        applyStimulus(D + 700, 1'b1);
        waitUntil(D + 780);
        checkOutput("req_780", ref_req, 0);
        waitUntil(D + 781);
        checkOutput("req_781", ref_req, 1);
        checkOutput("busy_781", ref_busy, 0);
        waitUntil(D + 782);
        checkOutput("busy_782", ref_busy, 1);
        checkOutput("req_782", ref_req, 1);
        waitUntil(D + 783);
        checkOutput("req_783", ref_req, 0);
        waitUntil(D + 788);
        checkOutput("busy_788", ref_busy, 1);
        waitUntil(D + 789);
        checkOutput("busy_789", ref_busy, 0);
        applyStimulus(D + 790, 1'b0);

        // Grant withheld across a full period: overrun.
        waitUntil(D + 1562);
        checkOutput("req_1562", ref_req, 1);
        checkOutput("ovr_1562", ref_overrun, 0);
        waitUntil(D + 2342);
        checkOutput("ovr_2342", ref_overrun, 0);
        waitUntil(D + 2343);
        checkOutput("ovr_2343", ref_overrun, 1);
        checkOutput("req_2343", ref_req, 1);
        pushExpected(D + 2351, CMD_AREF, 13'h000);
        applyStimulus(D + 2350, 1'b1);
        waitUntil(D + 2352);
        checkOutput("req_2352", ref_req, 0);
        applyStimulus(D + 2370, 1'b0);
        waitUntil(D + 2400);
        checkOutput("ovr_sticky", ref_overrun, 1);
        checkOutput("req_2400", ref_req, 0);
        checkOutput("q_end", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_init_refresh.md
# sdram_init_refresh

Power-up initialization sequencer and periodic auto-refresh engine for the board SDRAM. It sits directly downstream of the clock/reset generator and runs on the 100 MHz SDRAM controller clock once the delayed system reset releases. It drives the SDRAM command bus during initialization, then raises refresh requests to the read/write arbiter. When granted, it issues AUTO REFRESH commands.

## Interface
- CLK_MHZ, 100: controller clock frequency, used for the power-up wait.
- T_POWERUP_US, 200: power-up NOP wait in µs.
- T_RP, 2: PRECHARGE-to-command cycles.
- T_RFC, 7: AUTO REFRESH-to-command cycles.
- T_MRD, 2: MRS-to-command cycles.
- INIT_REFRESH, 8: AUTO REFRESH count during init.
- REFRESH_PERIOD, 781: cycles between refresh requests (7.8 µs).
- MODE_REG, 13'h032: MRS address value (CAS 3, BL4, sequential).
- clk  in  1  SDRAM controller clock.
- rst  in  1  synchronous, active-high reset.
- sdr_cke  out  1  clock enable.
- sdr_cmd  out  4  {cs_n, ras_n, cas_n, we_n}.
- sdr_addr  out  13  address bus.
- sdr_ba  out  2  bank address.
- init_done  out  1  level; init sequence complete.
- ref_req  out  1  refresh request to arbiter.
- ref_grant  in  1  arbiter grant; the bus belongs to this block next cycle.
- ref_busy  out  1  this block owns the command bus.
- ref_overrun  out  1  sticky; a refresh period expired while a request was pending.

## Operation
- Command encodings: NOP 4'b0111, PRECHARGE 4'b0010, AUTO REFRESH 4'b0001, MRS 4'b0000. Every command lasts exactly one cycle. NOP is driven in all other cycles.
- PRECHARGE drives sdr_addr[10]=1 (all banks). MRS drives sdr_addr=MODE_REG and sdr_ba=0. All other cycles drive addr=0 and ba=0.
- State machine:
  - S_PWRUP counts CLK_MHZ*T_POWERUP_US cycles, then goes to S_PRE.
  - S_PRE issues PRECHARGE for 1 cycle.
  - S_TRP waits T_RP-1 cycles.
  - S_IREF issues AREF for 1 cycle.
  - S_IRFC waits T_RFC-1 cycles, then returns to S_IREF until INIT_REFRESH AREFs are done.
  - S_MRS issues MRS for 1 cycle.
  - S_TMRD waits T_MRD-1 cycles.
  - S_IDLE is entered afterwards.
- In S_IDLE, the block waits for ref_req && ref_grant, then goes to S_AREF (AREF for 1 cycle), then S_RFC (T_RFC-1 cycles), then back to S_IDLE.
- init_done rises on entry to S_IDLE after init and stays high until reset.
- Refresh timer:
  - Free-running modulo-REFRESH_PERIOD counter, enabled from init_done.
  - On wrap, sets ref_req. If ref_req is already set at wrap, sets ref_overrun (sticky).
  - ref_req clears in the AREF cycle.
  - The timer never stops for grants, so the average period does not drift.
- ref_grant while ref_req is low, or during init, is ignored.
- ref_busy is high in every S_PRE through S_TMRD state and in S_AREF/S_RFC. The arbiter must not drive commands while it is high.
- A single wait counter (16 bits) is shared by all wait states and reloaded on each state entry. It is wide enough for 20 000.

## Timing
- Reset values: sdr_cke=0, sdr_cmd=NOP, sdr_addr=0, sdr_ba=0, init_done=0, ref_req=0, ref_busy=1, ref_overrun=0, state=S_PWRUP, all counters 0.
- sdr_cke goes high in the first cycle after rst deasserts. That cycle is cycle 0 of S_PWRUP.
- All outputs are registered.
- Grant sampled high in cycle n → AREF on sdr_cmd in cycle n+1. ref_req low from cycle n+2. ref_busy stays high for cycles n+1 … n+T_RFC.
- rst asserted mid-sequence (init or refresh) returns the block to the reset state on the next edge. The full init is re-run.

## Configuration
- SDRAM_SIM_FAST_INIT_EN defined: the S_PWRUP wait is fixed at 16 cycles, for simulation.
- Undefined: the wait is CLK_MHZ*T_POWERUP_US cycles.
- Nothing else changes.

## Structure
- Shared package sdram_pkg holds:
  - the command encoding constants;
  - the state enumeration typedef;
  - the default timing constants, which are shared with the read/write controller.
- One natural sub-module, sdram_refresh_timer, containing the modulo counter, ref_req and ref_overrun.

## Test plan
All scenarios use SDRAM_SIM_FAST_INIT_EN and default parameters. Cycle 0 is the first cycle after rst falls.
- Init sequence → PRECHARGE with addr[10]=1 at cycle 16. AREF at cycles 18, 25, 32, 39, 46, 53, 60, 67. MRS with addr=13'h032 at cycle 74. init_done and ref_busy=0 at cycle 76.
- Refresh timing → ref_req rises 781 cycles after init_done. With grant held high, AREF one cycle later and ref_busy high for 7 cycles.
- Grant withheld for 781 cycles after ref_req → ref_overrun=1 and ref_req stays high. A later grant gives exactly one AREF.
- ref_grant pulsed during init and while ref_req=0 → no AREF issued, sequence unchanged.
- rst pulsed at cycle 40 (mid init-refresh) → outputs return to reset values, and PRECHARGE reappears 16 cycles after the release.
- Build without the macro, CLK_MHZ=1, T_POWERUP_US=50 → first PRECHARGE at cycle 50.
